dsm_interp: RTL

Upstream feeder for `DSM_top`. Accepts 16-bit signed PCM samples over a valid/ready handshake at the audio rate and converts them to the modulator's 20-bit input format ([19:16] saturation/sign, [15] = 1 V, [14:0] fraction). It linearly interpolates between successive samples at the oversampling ratio, so the modulator's `vin` gets a new, smoothly ramped value on every clock. It also detects and counts source underruns.

---
 rtl/dsm_pkg.sv | 26 ++
 rtl/dsm_hold_reg.sv | 37 +++
 rtl/dsm_interp.sv | 136 +++++++++++++
 3 files changed

// File: rtl/dsm_pkg.sv
// Shared constants, state type and PCM-to-modulator conversion for the DSM front end.
package dsm_pkg;

  localparam int VIN_W = 20;
  localparam int PCM_W = 16;

  // Modulator input format: bit 15 is 1 V, bits [14:0] are fraction.
  localparam logic signed [VIN_W-1:0] VIN_FS          = 20'sh08000;
  localparam logic signed [VIN_W-1:0] VIN_FS_HALF     = 20'sh04000;
  localparam logic signed [VIN_W-1:0] VIN_FS_HALF_NEG = 20'shFC000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic signed [VIN_W-1:0] pcm_to_vin(
    input logic [PCM_W-1:0] pcm,
    input int unsigned      gain_shift
  );
    logic signed [VIN_W-1:0] ext;
    ext = $signed({{(VIN_W-PCM_W){pcm[PCM_W-1]}}, pcm});
    return ext >>> gain_shift;
  endfunction

endpackage

// File: rtl/dsm_hold_reg.sv
// One-entry sample holding register; converts PCM to the modulator format on capture.
module dsm_hold_reg
  import dsm_pkg::*;
#(
  parameter int GAIN_SHIFT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [PCM_W-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             consume,
  output logic [VIN_W-1:0] hold_data,
  output logic             hold_valid
);

  logic [VIN_W-1:0] data_q;
  logic             valid_q;

  assign s_ready    = ~valid_q & ~reset;
  assign hold_data  = data_q;
  assign hold_valid = valid_q;

  // Capture on handshake, release when the interpolator consumes the entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (s_valid && s_ready) begin
      data_q  <= pcm_to_vin(s_data, GAIN_SHIFT);
      valid_q <= 1'b1;
    end else if (consume) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/dsm_interp.sv
// Linear interpolator feeding DSM_top.vin: ramps between successive PCM samples over
// 2^LOG2_OSR clocks and counts source underruns.
module dsm_interp
  import dsm_pkg::*;
#(
  parameter int LOG2_OSR   = 6,
  parameter int GAIN_SHIFT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [PCM_W-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [VIN_W-1:0] vin,
  output logic             period_start,
  output logic             underrun,
  output logic [15:0]      underrun_count
);

  localparam int ACC_W = VIN_W + LOG2_OSR;
  localparam int OSR   = 1 << LOG2_OSR;
  localparam logic [LOG2_OSR-1:0] PH_LAST = LOG2_OSR'(OSR - 1);

  logic [VIN_W-1:0]        hold_data;
  logic                    hold_valid;
  logic                    consume;

  state_e                  state_q, state_d;
  logic signed [VIN_W-1:0] prev_q, prev_d;
  logic signed [VIN_W-1:0] target_q, target_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [LOG2_OSR-1:0]     phase_q, phase_d;
  logic [15:0]             ucnt_q, ucnt_d;
  logic                    und_q, und_d;
  logic                    ps_q, ps_d;
  logic [VIN_W-1:0]        vin_q, vin_d;
  logic signed [VIN_W:0]   delta_s;

  dsm_hold_reg #(
    .GAIN_SHIFT(GAIN_SHIFT)
  ) u_hold (
    .clock     (clock),
    .reset     (reset),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .consume   (consume),
    .hold_data (hold_data),
    .hold_valid(hold_valid)
  );

  assign delta_s = $signed({target_q[VIN_W-1], target_q}) - $signed({prev_q[VIN_W-1], prev_q});

  // Next-state: sequencing, accumulator update, period boundary handling.
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    target_d = target_q;
    acc_d    = acc_q;
    phase_d  = phase_q;
    ucnt_d   = ucnt_q;
    und_d    = 1'b0;
    consume  = 1'b0;
    case (state_q)
      IDLE: begin
        acc_d   = '0;
        phase_d = '0;
        if (hold_valid) begin
          consume  = 1'b1;
          state_d  = RUN;
          prev_d   = '0;
          target_d = $signed(hold_data);
        end else begin
          prev_d   = '0;
          target_d = '0;
        end
      end
      RUN: begin
        if (phase_q == PH_LAST) begin
          // Reload acc from target so every period starts exactly on the sample.
          prev_d  = target_q;
          acc_d   = ACC_W'(target_q) <<< LOG2_OSR;
          phase_d = '0;
          if (hold_valid) begin
            consume  = 1'b1;
            target_d = $signed(hold_data);
          end else begin
            und_d = 1'b1;
            if (ucnt_q != 16'hFFFF) begin
              ucnt_d = ucnt_q + 16'd1;
            end else begin
              ucnt_d = ucnt_q;
            end
          end
        end else begin
          acc_d   = acc_q + ACC_W'(delta_s);
          phase_d = phase_q + LOG2_OSR'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    ps_d  = (state_d == RUN) && (phase_d == '0);
    vin_d = VIN_W'(acc_d >>> LOG2_OSR);
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      prev_q   <= '0;
      target_q <= '0;
      acc_q    <= '0;
      phase_q  <= '0;
      ucnt_q   <= 16'd0;
      und_q    <= 1'b0;
      ps_q     <= 1'b0;
      vin_q    <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      target_q <= target_d;
      acc_q    <= acc_d;
      phase_q  <= phase_d;
      ucnt_q   <= ucnt_d;
      und_q    <= und_d;
      ps_q     <= ps_d;
      vin_q    <= vin_d;
    end
  end

  assign vin            = vin_q;
  assign period_start   = ps_q;
  assign underrun       = und_q;
  assign underrun_count = ucnt_q;

endmodule
